// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite bus bundle between a master/decoder and the ahb_slave_mem responder.
interface ahb_slave_mem_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  hsel;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hready;
    logic [DATA_WIDTH-1:0] hrdata;
    logic                  hreadyout;
    logic                  hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: byte-lane writes, runtime wait states, two-cycle ERROR
// response for out-of-range, misaligned or oversized transfers.
module ahb_slave_mem #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           WAIT_W     = 4
) (
    input  logic              hclk,
    input  logic              hreset,
    ahb_slave_mem_if.slave    bus,
    input  logic [WAIT_W-1:0] wait_cfg
);
    localparam int unsigned     STRB_W    = DATA_WIDTH / 8;
    localparam int unsigned     LANE_BITS = $clog2(STRB_W);
    localparam int unsigned     IDX_W     = $clog2(MEM_DEPTH);
    localparam longint unsigned MEM_BYTES = longint'(MEM_DEPTH) * longint'(STRB_W);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t                state_q;
    logic [WAIT_W-1:0]     cnt_q;
    logic                  hreadyout_q;
    logic                  hresp_q;
    logic [DATA_WIDTH-1:0] hrdata_q;
    logic                  dp_wr_q;
    logic                  dp_rd_q;
    logic [IDX_W-1:0]      idx_q;
    logic [LANE_BITS-1:0]  lane_q;
    logic [2:0]            hsize_q;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  accept_c;
    logic                  legal_c;
    logic                  commit_c;
    logic [ADDR_WIDTH:0]   offs_c;
    logic [ADDR_WIDTH-1:0] align_mask_c;
    logic [IDX_W-1:0]      idx_c;
    logic [STRB_W-1:0]     be_c;
    int unsigned           lane_lo_c;
    int unsigned           lane_hi_c;
    logic [DATA_WIDTH-1:0] rd_word_c;
    logic                  unused_htrans0;

    assign unused_htrans0 = bus.htrans[0];

    // Address-phase decode; extra offs_c bit flags haddr below BASE_ADDR.
    assign accept_c     = bus.hsel & bus.hready & bus.htrans[1] & hreadyout_q;
    assign offs_c       = {1'b0, bus.haddr} - {1'b0, BASE_ADDR};
    assign align_mask_c = ~({ADDR_WIDTH{1'b1}} << bus.hsize);
    assign idx_c        = offs_c[IDX_W+LANE_BITS-1:LANE_BITS];
    assign legal_c      = (bus.hsize <= 3'(LANE_BITS))
                        && ((bus.haddr & align_mask_c) == '0)
                        && !offs_c[ADDR_WIDTH]
                        && (64'(offs_c) < MEM_BYTES);

    // Write data phase ends on any edge where a legal write sees hreadyout high.
    assign commit_c = !hreset && dp_wr_q && hreadyout_q;

    always_comb begin
        be_c      = '0;
        lane_lo_c = 32'(lane_q);
        lane_hi_c = lane_lo_c + (32'd1 << hsize_q);
        for (int unsigned b = 0; b < STRB_W; b++) begin
            if (b >= lane_lo_c && b < lane_hi_c) be_c[b] = 1'b1;
        end
    end

    // Forward a committing write into a zero-wait read of the same word.
    always_comb begin
        rd_word_c = mem[idx_c];
        if (commit_c && idx_q == idx_c) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (be_c[b]) rd_word_c[8*b +: 8] = bus.hwdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (commit_c) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (be_c[b]) mem[idx_q][8*b +: 8] <= bus.hwdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
            dp_wr_q     <= 1'b0;
            dp_rd_q     <= 1'b0;
            idx_q       <= '0;
            lane_q      <= '0;
            hsize_q     <= '0;
        end else begin
            hrdata_q <= '0;
            if (commit_c) dp_wr_q <= 1'b0;
            case (state_q)
                S_IDLE, S_ERR2: begin
                    state_q     <= S_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b0;
                    if (accept_c) begin
                        idx_q   <= idx_c;
                        lane_q  <= bus.haddr[LANE_BITS-1:0];
                        hsize_q <= bus.hsize;
                        if (!legal_c) begin
                            state_q     <= S_ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= 1'b1;
                            dp_wr_q     <= 1'b0;
                            dp_rd_q     <= 1'b0;
                        end else begin
                            dp_wr_q <= bus.hwrite;
                            dp_rd_q <= !bus.hwrite;
                            if (wait_cfg != '0) begin
                                state_q     <= S_WAIT;
                                cnt_q       <= wait_cfg;
                                hreadyout_q <= 1'b0;
                            end else if (!bus.hwrite) begin
                                hrdata_q <= rd_word_c;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == WAIT_W'(1)) begin
                        state_q     <= S_IDLE;
                        hreadyout_q <= 1'b1;
                        if (dp_rd_q) hrdata_q <= mem[idx_q];
                    end
                    cnt_q <= cnt_q - WAIT_W'(1);
                end
                S_ERR1: begin
                    state_q     <= S_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hreadyout = hreadyout_q;
    assign bus.hresp     = hresp_q;
    assign bus.hrdata    = hrdata_q;
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: reset, zero-wait and waited transfers,
// byte lanes, ERROR responses and reset during a waited write.
module tb_ahb_slave_mem;
    logic       hclk = 1'b0;
    logic       hreset = 1'b1;
    logic [3:0] wait_cfg = 4'd0;
    int         checks = 0;
    int         errors = 0;

    ahb_slave_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    ahb_slave_mem #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(1024),
        .BASE_ADDR(32'h0), .WAIT_W(4)
    ) dut (
        .hclk(hclk), .hreset(hreset), .bus(bus), .wait_cfg(wait_cfg)
    );

    assign bus.hready = bus.hreadyout;

    always #5 hclk = ~hclk;

    task automatic step();
        @(posedge hclk);
        @(negedge hclk);
    endtask

    task automatic set_addr(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                            input logic [3:0] wc);
        bus.hsel   = 1'b1;
        bus.htrans = 2'd2;
        bus.haddr  = a;
        bus.hwrite = wr;
        bus.hsize  = sz;
        wait_cfg   = wc;
    endtask

    task automatic set_idle();
        bus.hsel   = 1'b0;
        bus.htrans = 2'd0;
        bus.hwrite = 1'b0;
    endtask

    // Single zero-wait write; leaves the bus idle at the next negedge.
    task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
        set_addr(a, 1'b1, sz, 4'd0);
        step();
        bus.hwdata = d;
        set_idle();
        step();
    endtask

    task automatic test_reset();
        repeat (2) begin
            @(negedge hclk);
            checks++;
            if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0 || bus.hrdata !== 32'h0) begin
                errors++;
                $display("FAIL reset_hold: ready=%b resp=%b rdata=%h want 1 0 0",
                         bus.hreadyout, bus.hresp, bus.hrdata);
            end
        end
        hreset = 1'b0;
        repeat (3) begin
            step();
            checks++;
            if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0 || bus.hrdata !== 32'h0) begin
                errors++;
                $display("FAIL reset_idle: ready=%b resp=%b rdata=%h want 1 0 0",
                         bus.hreadyout, bus.hresp, bus.hrdata);
            end
        end
    endtask

    task automatic test_busy();
        bus.hsel   = 1'b1;
        bus.htrans = 2'd1;
        bus.haddr  = 32'h0000_2000;
        step();
        checks++;
        if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0 || bus.hrdata !== 32'h0) begin
            errors++;
            $display("FAIL busy_okay: ready=%b resp=%b rdata=%h want 1 0 0",
                     bus.hreadyout, bus.hresp, bus.hrdata);
        end
        set_idle();
        step();
    endtask

    task automatic test_back_to_back();
        set_addr(32'h10, 1'b1, 3'd2, 4'd0);
        step();
        checks++;
        if (bus.hreadyout !== 1'b1) begin
            errors++;
            $display("FAIL b2b_write_ready: got %b want 1", bus.hreadyout);
        end
        bus.hwdata = 32'hDEAD_BEEF;
        set_addr(32'h10, 1'b0, 3'd2, 4'd0);
        step();
        checks++;
        if (bus.hrdata !== 32'hDEAD_BEEF || bus.hreadyout !== 1'b1) begin
            errors++;
            $display("FAIL b2b_read: rdata=%h ready=%b want deadbeef 1", bus.hrdata, bus.hreadyout);
        end
        set_idle();
        step();
        checks++;
        if (bus.hrdata !== 32'h0) begin
            errors++;
            $display("FAIL b2b_rdata_clear: got %h want 0", bus.hrdata);
        end
    endtask

    task automatic test_wait_states();
        int low;
        write_word(32'h20, 32'hCAFE_F00D, 3'd2);
        set_addr(32'h20, 1'b0, 3'd2, 4'd3);
        step();
        set_idle();
        wait_cfg = 4'd7;
        low = 0;
        for (int i = 0; i < 10 && bus.hreadyout === 1'b0; i++) begin
            low++;
            checks++;
            if (bus.hrdata !== 32'h0 || bus.hresp !== 1'b0) begin
                errors++;
                $display("FAIL wait_outputs: rdata=%h resp=%b want 0 0", bus.hrdata, bus.hresp);
            end
            step();
        end
        checks++;
        if (low != 3) begin
            errors++;
            $display("FAIL wait_count: got %0d want 3", low);
        end
        checks++;
        if (bus.hreadyout !== 1'b1 || bus.hrdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL wait_data: ready=%b rdata=%h want 1 cafef00d", bus.hreadyout, bus.hrdata);
        end
        wait_cfg = 4'd0;
        step();
    endtask

    task automatic test_byte_write();
        write_word(32'h30, 32'h1122_3344, 3'd2);
        write_word(32'h32, 32'h00AB_0000, 3'd0);
        set_addr(32'h30, 1'b0, 3'd2, 4'd0);
        step();
        checks++;
        if (bus.hrdata !== 32'h11AB_3344) begin
            errors++;
            $display("FAIL byte_write: got %h want 11ab3344", bus.hrdata);
        end
        set_idle();
        step();
    endtask

    task automatic test_errors();
        set_addr(32'h1000, 1'b0, 3'd2, 4'd0);
        step();
        set_idle();
        checks++;
        if (bus.hreadyout !== 1'b0 || bus.hresp !== 1'b1) begin
            errors++;
            $display("FAIL range_err1: ready=%b resp=%b want 0 1", bus.hreadyout, bus.hresp);
        end
        step();
        checks++;
        if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b1) begin
            errors++;
            $display("FAIL range_err2: ready=%b resp=%b want 1 1", bus.hreadyout, bus.hresp);
        end
        step();
        checks++;
        if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0) begin
            errors++;
            $display("FAIL range_okay: ready=%b resp=%b want 1 0", bus.hreadyout, bus.hresp);
        end

        write_word(32'h00, 32'h5566_7788, 3'd2);
        set_addr(32'h02, 1'b1, 3'd2, 4'd0);
        step();
        bus.hwdata = 32'hFFFF_FFFF;
        set_idle();
        checks++;
        if (bus.hreadyout !== 1'b0 || bus.hresp !== 1'b1) begin
            errors++;
            $display("FAIL misalign_err1: ready=%b resp=%b want 0 1", bus.hreadyout, bus.hresp);
        end
        step();
        checks++;
        if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b1) begin
            errors++;
            $display("FAIL misalign_err2: ready=%b resp=%b want 1 1", bus.hreadyout, bus.hresp);
        end
        step();
        checks++;
        if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0) begin
            errors++;
            $display("FAIL misalign_okay: ready=%b resp=%b want 1 0", bus.hreadyout, bus.hresp);
        end
        set_addr(32'h00, 1'b0, 3'd2, 4'd0);
        step();
        checks++;
        if (bus.hrdata !== 32'h5566_7788) begin
            errors++;
            $display("FAIL misalign_mem: got %h want 55667788", bus.hrdata);
        end
        set_idle();
        step();
    endtask

    task automatic test_reset_mid();
        write_word(32'h40, 32'h1234_5678, 3'd2);
        set_addr(32'h40, 1'b1, 3'd2, 4'd4);
        step();
        bus.hwdata = 32'hA5A5_A5A5;
        set_idle();
        wait_cfg = 4'd0;
        step();
        checks++;
        if (bus.hreadyout !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_wait: ready=%b want 0", bus.hreadyout);
        end
        hreset = 1'b1;
        step();
        hreset = 1'b0;
        checks++;
        if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: ready=%b resp=%b want 1 0", bus.hreadyout, bus.hresp);
        end
        step();
        set_addr(32'h40, 1'b0, 3'd2, 4'd0);
        step();
        checks++;
        if (bus.hrdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rst_mid_mem: got %h want 12345678", bus.hrdata);
        end
        set_idle();
        step();
    endtask

    initial begin
        bus.hsel   = 1'b0;
        bus.htrans = 2'd0;
        bus.haddr  = 32'h0;
        bus.hwrite = 1'b0;
        bus.hsize  = 3'd2;
        bus.hwdata = 32'h0;
        test_reset();
        test_busy();
        test_back_to_back();
        test_wait_states();
        test_byte_write();
        test_errors();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
